// File: rtl/fmap_writer.sv
// Feature-map write-back engine: crops a padded raster stream and writes the interior
// pixels at a fixed row pitch through a small FIFO. Optional ReLU via FMAP_WRITER_RELU_EN.
module fmap_writer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 13,
    parameter int ROW_PITCH  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [6:0]        in_w,
    input  logic [6:0]        in_h,
    input  logic [3:0]        crop_x,
    input  logic [3:0]        crop_y,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mem_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [6:0]        w_reg, h_reg, x_reg, y_reg;
    logic [3:0]        cx_reg, cy_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              mem_we_reg, done_reg, cfg_err_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

    logic              cfg_ok, full, empty, accept, push, pop;
    logic              x_last, y_last, x_keep, y_keep;
    logic              latch_cfg, err_set, finish;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    assign cfg_ok = (in_w > {2'b00, crop_x, 1'b0}) && (in_h > {2'b00, crop_y, 1'b0});
    assign full   = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign empty  = (count_reg == '0);

    // Deliberately ignores a same-cycle pop: ready depends only on registered state.
    assign in_ready = (state_reg == RUN) && !full;
    assign accept   = in_valid && in_ready;
    assign pop      = !empty && mem_grant;

    assign x_last = (x_reg == w_reg - 7'd1);
    assign y_last = (y_reg == h_reg - 7'd1);
    assign x_keep = (x_reg >= {3'b000, cx_reg}) && (x_reg < w_reg - {3'b000, cx_reg});
    assign y_keep = (y_reg >= {3'b000, cy_reg}) && (y_reg < h_reg - {3'b000, cy_reg});
    assign push   = accept && x_keep && y_keep;

    assign push_addr = ADDR_W'(x_reg - {3'b000, cx_reg})
                     + ADDR_W'(y_reg - {3'b000, cy_reg}) * ADDR_W'(ROW_PITCH);

`ifdef FMAP_WRITER_RELU_EN
    assign push_data = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign push_data = in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        latch_cfg  = 1'b0;
        err_set    = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_next = RUN;
                        latch_cfg  = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept && x_last && y_last) state_next = DRAIN;
            end
            DRAIN: begin
                // An empty FIFO means the final pop (if any) is being written this cycle.
                if (empty) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_reg] <= push_addr;
            fifo_data[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg         <= '0;
            h_reg         <= '0;
            cx_reg        <= '0;
            cy_reg        <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            done_reg      <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            done_reg <= finish;
            if (latch_cfg) begin
                w_reg       <= in_w;
                h_reg       <= in_h;
                cx_reg      <= crop_x;
                cy_reg      <= crop_y;
                x_reg       <= '0;
                y_reg       <= '0;
                cfg_err_reg <= 1'b0;
            end else begin
                if (err_set) cfg_err_reg <= 1'b1;
                if (accept) begin
                    if (x_last) begin
                        x_reg <= '0;
                        y_reg <= y_reg + 7'd1;
                    end else begin
                        x_reg <= x_reg + 7'd1;
                    end
                end
            end

            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            mem_we_reg <= pop;
            if (pop) begin
                mem_addr_reg  <= fifo_addr[rd_ptr_reg];
                mem_wdata_reg <= fifo_data[rd_ptr_reg];
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_fmap_writer.sv
// Randomized bench for fmap_writer: expected writes come from an arithmetic crop/address
// model over each generated frame. Honours FMAP_WRITER_RELU_EN when the RTL is built with it.
module tb_fmap_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  in_w = '0, in_h = '0;
    logic [3:0]  crop_x = '0, crop_y = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        mem_grant;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy, done, cfg_err;

    fmap_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_w(in_w), .in_h(in_h),
        .crop_x(crop_x), .crop_y(crop_y), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mem_grant(mem_grant), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int          pix[$];
    logic [12:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    int          done_cnt = 0;
    logic        busy_at_done = 1'b0;
    time         last_we_t = 0, done_t = 0, first_we_t = 0, first_fire_t = 0;
    bit          seen_we = 1'b0, seen_fire = 1'b0;
    int          grant_prob = 100;
    int          stall_left = 0;
    int          stall_idx = 0;
    logic        stall_ready = 1'b0;

    // Memory-side monitor: every write strobe becomes one observed transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                obs_addr.push_back(mem_addr);
                obs_data.push_back(mem_wdata);
                last_we_t = $time;
                if (!seen_we) begin
                    seen_we    = 1'b1;
                    first_we_t = $time;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_t       = $time;
                busy_at_done = busy;
            end
        end
    end

    initial begin
        mem_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_left > 0) begin
                mem_grant = 1'b0;
                stall_left--;
            end else begin
                mem_grant = ($urandom_range(99) < grant_prob);
            end
        end
    end

    function automatic logic [7:0] model_data(int v);
`ifdef FMAP_WRITER_RELU_EN
        return (v >= 128) ? 8'd0 : 8'(v);
`else
        return 8'(v);
`endif
    endfunction

    // Drives one frame in raster order; abort_at > 0 pulls reset after that many pixels.
    task automatic send_frame(int w, int h, int cx, int cy, int vprob, int stall,
                              bit keep_pix, int abort_at);
        int idx = 0;
        int cycles = 0;
        bit fire;
        if (!keep_pix) begin
            pix.delete();
            for (int i = 0; i < w * h; i++) pix.push_back(int'($urandom_range(255)));
        end
        obs_addr.delete();
        obs_data.delete();
        done_cnt  = 0;
        seen_we   = 1'b0;
        seen_fire = 1'b0;
        @(posedge clk); #1;
        in_w = 7'(w); in_h = 7'(h); crop_x = 4'(cx); crop_y = 4'(cy);
        start = 1'b1;
        stall_left = stall;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < w * h && cycles < 20000) begin
            if (abort_at > 0 && idx >= abort_at) begin
                rst_n = 1'b0;
                break;
            end
            in_valid = ($urandom_range(99) < vprob);
            in_data  = 8'(pix[idx]);
            @(negedge clk);
            fire = in_valid && in_ready;
            if (fire && !seen_fire) begin
                seen_fire    = 1'b1;
                first_fire_t = $time;
            end
            @(posedge clk); #1;
            if (fire) idx++;
            cycles++;
            if (stall > 0 && cycles == 18) begin
                stall_idx   = idx;
                stall_ready = in_ready;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (cycles >= 20000) begin
            miscompares++;
            $display("FAIL stream_timeout: accepted %0d pixels, required %0d", idx, w * h);
        end
    endtask

    task automatic wait_done(string name);
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt == 0) begin
            miscompares++;
            $display("FAIL %s done_timeout: no done within %0d cycles, required 1 pulse", name, t);
        end
    endtask

    task automatic check_frame(string name, int w, int h, int cx, int cy);
        int n = 0;
        logic [12:0] ea;
        logic [7:0]  ed;
        for (int y = cy; y < h - cy; y++) begin
            for (int x = cx; x < w - cx; x++) begin
                ea = 13'((x - cx) + 64 * (y - cy));
                ed = model_data(pix[y * w + x]);
                vectors++;
                if (n >= obs_addr.size()) begin
                    miscompares++;
                    if (n - obs_addr.size() < 4)
                        $display("FAIL %s write%0d: missing, required addr %0d data %02h", name, n, ea, ed);
                end else if (obs_addr[n] !== ea || obs_data[n] !== ed) begin
                    miscompares++;
                    $display("FAIL %s write%0d: got addr %0d data %02h, required addr %0d data %02h",
                             name, n, obs_addr[n], obs_data[n], ea, ed);
                end
                n++;
            end
        end
        vectors++;
        if (obs_addr.size() != n) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d, required %0d", name, obs_addr.size(), n);
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt);
        end
        vectors++;
        if (busy_at_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after_done: got %b/%b, required 0/0", name, busy_at_done, busy);
        end
        $display("frame %s %0dx%0d crop %0d,%0d: %0d writes observed", name, w, h, cx, cy, obs_addr.size());
    endtask

    task automatic check_idle_outputs(string name);
        vectors++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, cfg_err} !== '0) begin
            miscompares++;
            $display("FAIL %s reset_outputs: got ready=%b we=%b addr=%0d wdata=%02h busy=%b done=%b err=%b, required all 0",
                     name, in_ready, mem_we, mem_addr, mem_wdata, busy, done, cfg_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("power_on");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        grant_prob = 100;
        send_frame(66, 66, 1, 1, 100, 0, 1'b0, 0);
        wait_done("full66");
        check_frame("full66", 66, 66, 1, 1);
    endtask

    task automatic test_small_crop();
        grant_prob = 100;
        send_frame(5, 5, 1, 2, 100, 0, 1'b0, 0);
        wait_done("small5");
        check_frame("small5", 5, 5, 1, 2);
    endtask

    task automatic test_latency_done();
        grant_prob = 100;
        send_frame(6, 5, 0, 0, 100, 0, 1'b0, 0);
        wait_done("latency");
        check_frame("latency", 6, 5, 0, 0);
        vectors++;
        if (first_we_t - first_fire_t != 20) begin
            miscompares++;
            $display("FAIL latency first_write: got %0t after accept, required 20", first_we_t - first_fire_t);
        end
        vectors++;
        if (done_t - last_we_t != 10) begin
            miscompares++;
            $display("FAIL done_timing: done %0t after last write, required 10", done_t - last_we_t);
        end
    endtask

    task automatic test_backpressure();
        grant_prob = 100;
        send_frame(10, 10, 1, 1, 100, 20, 1'b0, 0);
        vectors++;
        if (stall_idx != 15 || stall_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure stall: got %0d accepted ready=%b, required 15 accepted ready=0",
                     stall_idx, stall_ready);
        end
        wait_done("stall");
        check_frame("stall", 10, 10, 1, 1);
    endtask

    task automatic test_cfg_err();
        @(posedge clk); #1;
        in_w = 7'd4; in_h = 7'd6; crop_x = 4'd2; crop_y = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_err_set: got err=%b busy=%b ready=%b, required 1/0/0", cfg_err, busy, in_ready);
        end
        @(posedge clk); #1;
        in_w = 7'd9; in_h = 7'd5; crop_x = 4'd1; crop_y = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_err_sticky: got err=%b busy=%b, required 1/0", cfg_err, busy);
        end
        grant_prob = 100;
        send_frame(8, 6, 1, 1, 100, 0, 1'b0, 0);
        wait_done("after_err");
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_err_clear: got %b, required 0", cfg_err);
        end
        check_frame("after_err", 8, 6, 1, 1);
    endtask

    task automatic test_reset_midframe();
        grant_prob = 60;
        send_frame(20, 8, 2, 1, 100, 0, 1'b0, 70);
        @(negedge clk);
        check_idle_outputs("mid_reset");
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL mid_reset_done: got %0d pulses, required 0", done_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        obs_addr.delete();
        obs_data.delete();
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (obs_addr.size() != 0) begin
            miscompares++;
            $display("FAIL stale_writes: got %0d writes while idle, required 0", obs_addr.size());
        end
        send_frame(12, 6, 1, 1, 80, 0, 1'b0, 0);
        wait_done("post_reset");
        check_frame("post_reset", 12, 6, 1, 1);
    endtask

    task automatic test_relu_values();
        pix.delete();
        for (int i = 0; i < 12; i++) pix.push_back(int'($urandom_range(255)));
        pix[5] = 'hF0;
        pix[6] = 'h35;
        grant_prob = 100;
        send_frame(4, 3, 1, 1, 100, 0, 1'b1, 0);
        wait_done("relu");
        check_frame("relu", 4, 3, 1, 1);
    endtask

    task automatic test_random_frames();
        int w, h, cx, cy;
        for (int k = 0; k < 5; k++) begin
            w  = int'($urandom_range(3, 40));
            h  = int'($urandom_range(3, 30));
            cx = int'($urandom_range(0, (w - 1) / 2));
            cy = int'($urandom_range(0, (h - 1) / 2));
            if (cx > 15) cx = 15;
            if (cy > 15) cy = 15;
            grant_prob = int'($urandom_range(20, 100));
            send_frame(w, h, cx, cy, int'($urandom_range(30, 100)), 0, 1'b0, 0);
            wait_done("random");
            check_frame("random", w, h, cx, cy);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_small_crop();
        test_latency_done();
        test_backpressure();
        test_cfg_err();
        test_reset_midframe();
        test_relu_values();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
